// File: rtl/led_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl_if
//  Brief    : Host configuration handshake bundle for the LED sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface led_seq_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_step;
    logic [7:0]  cfg_loops;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_step,
        output cfg_loops,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_step,
        input  cfg_loops,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl
//  Brief    : Configurable 4-LED pattern sequencer with period timer, loop
//             count, start/stop/pause control. LEDs are active-low.
//  Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
    parameter logic [31:0] STEP_DEFAULT = 32'd50_000_000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    led_seq_ctrl_if.slave   cfg,
    input  wire logic       start,
    input  wire logic       stop,
    input  wire logic       pause,
    output logic [3:0]      led,
    output logic            busy,
    output logic            step_pulse,
    output logic            done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [3:0] c_LED_OFF = 4'b1111;

    logic [1:0]  state_q,      state_d;
    logic [1:0]  mode_q,       mode_d;
    logic [31:0] step_q,       step_d;
    logic [7:0]  loops_q,      loops_d;
    logic [31:0] timer_q,      timer_d;
    logic [1:0]  phase_q,      phase_d;
    logic [7:0]  loop_cnt_q,   loop_cnt_d;
    logic [3:0]  led_q,        led_d;
    logic        busy_q,       busy_d;
    logic        step_pulse_q, step_pulse_d;
    logic        done_q,       done_d;
    logic        cfg_ready_q,  cfg_ready_d;

    logic        w_cfg_acc;
    logic [1:0]  w_mode_eff;
    logic [1:0]  w_phase_nxt;
    logic        w_phase_end;
    logic        w_last_pass;

    function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [1:0] phase);
        logic [3:0] p;
        p = c_LED_OFF;
        case (mode)
            2'd0: case (phase)
                2'd0: p = 4'b1110;
                2'd1: p = 4'b1101;
                2'd2: p = 4'b1011;
                default: p = 4'b0111;
            endcase
            2'd1: case (phase)
                2'd0: p = 4'b0111;
                2'd1: p = 4'b1011;
                2'd2: p = 4'b1101;
                default: p = 4'b1110;
            endcase
            2'd2: case (phase)
                2'd0: p = 4'b1110;
                2'd1: p = 4'b1100;
                2'd2: p = 4'b1000;
                default: p = 4'b0000;
            endcase
            default: p = phase[0] ? 4'b1111 : 4'b0000;
        endcase
        return p;
    endfunction

    // cfg_ready_q is high exactly in IDLE, so it doubles as the accept gate
    assign w_cfg_acc   = cfg.cfg_valid & cfg_ready_q;
    assign w_mode_eff  = w_cfg_acc ? cfg.cfg_mode : mode_q;
    assign w_phase_nxt = phase_q + 2'd1;
    assign w_phase_end = (timer_q == (step_q - 32'd1));
    assign w_last_pass = (loop_cnt_q == (loops_q - 8'd1));

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        step_d       = step_q;
        loops_d      = loops_q;
        timer_d      = timer_q;
        phase_d      = phase_q;
        loop_cnt_d   = loop_cnt_q;
        led_d        = led_q;
        step_pulse_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            c_IDLE: begin
                led_d = c_LED_OFF;
                if (w_cfg_acc) begin
                    mode_d  = cfg.cfg_mode;
                    step_d  = (cfg.cfg_step == 32'd0) ? STEP_DEFAULT : cfg.cfg_step;
                    loops_d = cfg.cfg_loops;
                end
                if (start && !stop) begin
                    state_d    = c_RUN;
                    timer_d    = 32'd0;
                    phase_d    = 2'd0;
                    loop_cnt_d = 8'd0;
                    led_d      = pattern(w_mode_eff, 2'd0);
                end
            end
            c_RUN, c_PAUSE: begin
                if (stop) begin
                    state_d = c_IDLE;
                    led_d   = c_LED_OFF;
                end else if (pause) begin
                    state_d = c_PAUSE;
                end else begin
                    // The release edge already counts, so a pause of N cycles stretches a phase by exactly N
                    state_d = c_RUN;
                    if (w_phase_end) begin
                        timer_d      = 32'd0;
                        phase_d      = w_phase_nxt;
                        led_d        = pattern(mode_q, w_phase_nxt);
                        step_pulse_d = 1'b1;
                        if ((phase_q == 2'd3) && (loops_q != 8'd0)) begin
                            if (w_last_pass) begin
                                state_d = c_IDLE;
                                led_d   = c_LED_OFF;
                                done_d  = 1'b1;
                            end else begin
                                loop_cnt_d = loop_cnt_q + 8'd1;
                            end
                        end
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                led_d   = c_LED_OFF;
            end
        endcase

        busy_d      = (state_d != c_IDLE);
        cfg_ready_d = (state_d == c_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= c_IDLE;
            mode_q       <= 2'd0;
            step_q       <= STEP_DEFAULT;
            loops_q      <= 8'd0;
            timer_q      <= 32'd0;
            phase_q      <= 2'd0;
            loop_cnt_q   <= 8'd0;
            led_q        <= c_LED_OFF;
            busy_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            step_q       <= step_d;
            loops_q      <= loops_d;
            timer_q      <= timer_d;
            phase_q      <= phase_d;
            loop_cnt_q   <= loop_cnt_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            step_pulse_q <= step_pulse_d;
            done_q       <= done_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign led           = led_q;
    assign busy          = busy_q;
    assign step_pulse    = step_pulse_q;
    assign done          = done_q;
    assign cfg.cfg_ready = cfg_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_seq_ctrl
//  Brief    : Self-checking bench: directed vector table, hand sequences and
//             randomized traffic against an elapsed-time reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int SD = 5;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] led;
    logic       busy;
    logic       step_pulse;
    logic       done;

    led_seq_ctrl_if cfg_if ();

    led_seq_ctrl #(.STEP_DEFAULT(32'd5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg_if.slave),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .led        (led),
        .busy       (busy),
        .step_pulse (step_pulse),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: sequencing is tracked as the number of unpaused RUN cycles
    bit     m_run;
    int     m_mode;
    longint m_step;
    longint m_loops;
    longint m_el;
    bit     m_sp;
    bit     m_done;

    function automatic logic [3:0] ref_pat(input int mode, input longint ph);
        int v;
        case (mode)
            0:       v = ~(1 << ph);
            1:       v = ~(8 >> ph);
            2:       v = 15 << (ph + 1);
            default: v = (ph % 2 == 1) ? 15 : 0;
        endcase
        return 4'(v & 15);
    endfunction

    function automatic logic [3:0] m_led();
        if (!m_run) return 4'hF;
        return ref_pat(m_mode, (m_el / m_step) % 4);
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_step = SD; m_loops = 0; m_el = 0;
        m_sp = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_sp   = 0;
        m_done = 0;
        if (!m_run) begin
            if (cfg_if.cfg_valid) begin
                m_mode  = int'(cfg_if.cfg_mode);
                m_step  = (cfg_if.cfg_step == 0) ? SD : longint'(cfg_if.cfg_step);
                m_loops = longint'(cfg_if.cfg_loops);
            end
            if (start && !stop) begin
                m_run = 1;
                m_el  = 0;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (!pause) begin
            m_el++;
            if (m_el % m_step == 0) m_sp = 1;
            if (m_loops != 0 && m_el == m_loops * 4 * m_step) begin
                m_done = 1;
                m_run  = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("led",        32'(led),              32'(m_led()));
        chk("busy",       32'(busy),             32'(m_run));
        chk("cfg_ready",  32'(cfg_if.cfg_ready), 32'(!m_run));
        chk("step_pulse", 32'(step_pulse),       32'(m_sp));
        chk("done",       32'(done),             32'(m_done));
    endtask

    task automatic cyc(input logic cv, input logic [1:0] md, input logic [31:0] st,
                       input logic [7:0] lp, input logic s, input logic sp, input logic p);
        cfg_if.cfg_valid = cv;
        cfg_if.cfg_mode  = md;
        cfg_if.cfg_step  = st;
        cfg_if.cfg_loops = lp;
        start = s;
        stop  = sp;
        pause = p;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic        cv;
        logic [1:0]  md;
        logic [31:0] st;
        logic [7:0]  lp;
        logic        s, sp, p;
        logic [3:0]  e_led;
        logic        e_busy, e_rdy, e_sp, e_done;
    } vec_t;

    function automatic vec_t v(input logic cv, input logic [1:0] md, input logic [31:0] st,
                               input logic [7:0] lp, input logic s, input logic sp, input logic p,
                               input logic [3:0] e_led, input logic e_busy, input logic e_rdy,
                               input logic e_sp, input logic e_done);
        vec_t r;
        r.cv = cv; r.md = md; r.st = st; r.lp = lp; r.s = s; r.sp = sp; r.p = p;
        r.e_led = e_led; r.e_busy = e_busy; r.e_rdy = e_rdy; r.e_sp = e_sp; r.e_done = e_done;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        int cnt;
        // Chase-up, step 4, one pass: each row is the state seen after its edge
        tbl[0]  = v(1, 0, 4, 1, 1, 0, 0, 4'b1110, 1, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1110, 1, 0, 0, 0);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1110, 1, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1110, 1, 0, 0, 0);
        tbl[4]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1101, 1, 0, 1, 0);
        tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1101, 1, 0, 0, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1101, 1, 0, 0, 0);
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1101, 1, 0, 0, 0);
        tbl[8]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1011, 1, 0, 1, 0);
        tbl[9]  = v(0, 0, 0, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0);
        tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 4'b1011, 1, 0, 0, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 4'b0111, 1, 0, 1, 0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 4'b0111, 1, 0, 0, 0);
        tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 4'b0111, 1, 0, 0, 0);
        tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 4'b0111, 1, 0, 0, 0);
        tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 1, 1, 1);
        tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 1, 0, 0);

        cfg_if.cfg_valid = 0; cfg_if.cfg_mode = 0; cfg_if.cfg_step = 0; cfg_if.cfg_loops = 0;
        start = 0; stop = 0; pause = 0;
        rst_n = 0;
        model_reset();
        #23;
        chk("rst_led",   32'(led),              32'hF);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_busy",  32'(busy),             32'd0);
        @(negedge clk);
        rst_n = 1;
        idle(2);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].cv, tbl[i].md, tbl[i].st, tbl[i].lp, tbl[i].s, tbl[i].sp, tbl[i].p);
            chk($sformatf("tbl%0d_led", i),  32'(led),              32'(tbl[i].e_led));
            chk($sformatf("tbl%0d_busy", i), 32'(busy),             32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_rdy", i),  32'(cfg_if.cfg_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_sp", i),   32'(step_pulse),       32'(tbl[i].e_sp));
            chk($sformatf("tbl%0d_done", i), 32'(done),             32'(tbl[i].e_done));
        end

        // Fill forever with a 5-cycle pause inside phase 1
        cnt = 0;
        cyc(1, 2, 3, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (led == 4'b1100) cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            if (led == 4'b1100) cnt++;
            chk("pause_sp", 32'(step_pulse), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (led == 4'b1100) cnt++;
        end
        chk("pause_hold_cnt", 32'(cnt), 32'd8);
        chk("resume_led", 32'(led), 32'b1000);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("forever_nodone", 32'(done), 32'd0);
        end
        chk("forever_busy", 32'(busy), 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 0);

        // Blink, stop in phase 2, then start+stop together in IDLE
        cyc(1, 3, 2, 0, 1, 0, 0);
        idle(4);
        chk("blink_ph2_led", 32'(led), 32'b0000);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("stop_led",  32'(led),  32'hF);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("startstop_busy", 32'(busy), 32'd0);

        // Config offered while busy is refused; default step used afterwards
        cyc(1, 0, 4, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("busy_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("busy_cfg_ignored", 32'(led), 32'b1110);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cnt = (led == 4'b0111) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (led == 4'b0111) cnt++;
        end
        chk("default_step_hold", 32'(cnt), 32'(SD));
        chk("default_step_ph1", 32'(led), 32'b1011);

        // Asynchronous reset mid-phase
        idle(2);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_led",   32'(led),              32'hF);
        chk("arst_busy",  32'(busy),             32'd0);
        chk("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("arst_sp",    32'(step_pulse),       32'd0);
        chk("arst_done",  32'(done),             32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 6) == 0, 2'($urandom % 4), 32'($urandom % 5), 8'($urandom % 3),
                ($urandom % 5) == 0, ($urandom % 60) == 0, ($urandom % 8) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Programmable sequencer for the 4-LED bank: owns the period timer and drives the LED pattern.
- Host config (mode, step period, loop count) is loaded through a valid/ready handshake while the sequencer is idle.
- Sequencing is then controlled by start, stop and pause.
- Replaces hard-wired per-pattern timer/LED blocks with one configurable controller.

Parameters:
- STEP_DEFAULT, 32'd50_000_000, step period in clk cycles used when cfg_step==0 (1 s at 50 MHz).

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config offered.
- cfg_ready  out  1  config accepted when high with cfg_valid.
- cfg_mode  in  2  0 chase-up, 1 chase-down, 2 fill, 3 blink.
- cfg_step  in  32  cycles per phase; 0 selects STEP_DEFAULT.
- cfg_loops  in  8  full 4-phase passes before auto-stop; 0 = run forever.
- start  in  1  begin sequence (IDLE only).
- stop  in  1  abort to IDLE.
- pause  in  1  level; freezes sequence while high.
- led  out  4  LED drive, active-low (1 = off).
- busy  out  1  high in RUN or PAUSE.
- step_pulse  out  1  one-cycle pulse on each phase advance.
- done  out  1  one-cycle pulse on loop-count completion.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; led=4'b1111, busy=0, step_pulse=0, done=0, cfg_ready=1.
  - Shadow regs: mode=0, step=STEP_DEFAULT, loops=0; timer=0, phase=0, loop_cnt=0.
  - Reset mid-operation aborts immediately; no done pulse.
- States:
  - IDLE: cfg_ready=1, busy=0, led=1111.
  - RUN: busy=1.
  - PAUSE: busy=1.
  - cfg_ready=0 outside IDLE.
- Config: cfg_valid&cfg_ready at an edge latches mode, step (0 -> STEP_DEFAULT) and loops. cfg_valid outside IDLE is not accepted and shadow regs are unchanged.
- IDLE->RUN:
  - On start=1 & stop=0; config accepted on the same edge is used.
  - Next cycle: timer=0, phase=0, loop_cnt=0, led=pattern(mode,0).
  - start&stop together: stay IDLE.
- RUN timing:
  - timer increments each cycle.
  - At the edge where timer==step-1: timer<=0, phase<=phase+1 (mod 4), led<=pattern(next phase), step_pulse<=1 for one cycle.
  - Each phase is therefore visible exactly step cycles. step==1 advances every cycle.
- Loop count: on the 3->0 wrap with loops!=0:
  - If loop_cnt==loops-1: go to IDLE, led<=1111, done<=1 for one cycle. step_pulse is also asserted on that edge.
  - Otherwise loop_cnt<=loop_cnt+1.
  - loop_cnt is 8-bit.
- RUN->PAUSE: pause=1 at an edge.
  - timer, phase, loop_cnt and led hold.
  - No step_pulse, even if timer==step-1.
- PAUSE->RUN: pause=0; counting resumes from the held timer value.
- Stop:
  - stop=1 in RUN or PAUSE -> IDLE next cycle, led=1111, no done.
  - stop has priority over pause, wrap and auto-stop on the same edge.
  - start in RUN/PAUSE is ignored.
- Patterns (led value, phases 0..3):
  - mode0: 1110, 1101, 1011, 0111.
  - mode1: 0111, 1011, 1101, 1110.
  - mode2: 1110, 1100, 1000, 0000.
  - mode3: 0000, 1111, 0000, 1111.
- Registers and arithmetic:
  - All outputs are registered.
  - timer is a 32-bit unsigned compare against step-1; no timer overflow, since step>=1.

Test Plan:
- Reset then idle: led=1111, cfg_ready=1, busy=0.
- Chase-up with auto-stop:
  - Stimulus: cfg mode=0, step=4, loops=1; pulse start.
  - led 1110, 1101, 1011, 0111, each held 4 cycles.
  - step_pulse on each advance (4 total).
  - done one cycle after the 16th RUN cycle; led=1111, busy=0.
- Fill, run forever, with pause: mode=2, step=3, loops=0; assert pause for 5 cycles mid-phase 1.
  - led holds 1100 for 3+5 cycles.
  - No step_pulse during pause.
  - Resumes 1000 with the correct remaining count.
  - Runs past 8 phases without done.
- Stop during run: mode=3, step=2, stop at phase 2.
  - Next cycle: led=1111, busy=0, no done.
  - Same-edge start+stop in IDLE stays IDLE.
- Config gating: cfg_valid with mode=1 while busy is not accepted (cfg_ready=0).
  - After stop, offer mode=1, step=0.
  - Run shows 0111 held STEP_DEFAULT cycles; use a small STEP_DEFAULT override, e.g. 5.
- Async reset asserted mid-phase in RUN: all outputs return to reset values without waiting for a clk edge.
